seq_signed_mult: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/shift_add_step.sv | 24 ++
 rtl/seq_signed_mult.sv | 119 +++++++++++
 tb/tb_seq_signed_mult.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU multiply sequencer: FSM state encoding,
// default operand width and a counter-width helper.
package alu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        MUL  = 2'd2,
        SIGN = 2'd3
    } state_t;

    // $clog2 yields 0 for a width of 1; a counter still needs one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-and-add iteration: conditionally add the multiplicand to the upper
// accumulator half, then shift {carry, hi, lo} right by one bit.
module shift_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, hi};
        if (lo[0]) begin
            sum = {1'b0, hi} + {1'b0, mcand};
        end
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_signed_mult.sv
// Multi-cycle signed multiplier: magnitude conversion, WIDTH shift-add steps,
// then sign restore. Define SEQ_MULT_OVF_EN to add the ovf output.
module seq_signed_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
`ifdef SEQ_MULT_OVF_EN
    output logic                 ovf,
`endif
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);
    localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic              neg;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]   hi_step;
    logic [WIDTH-1:0]   lo_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] p_next;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .hi      (hi),
        .lo      (lo),
        .mcand   (mcand),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    // Zero stays zero under negation, so no special case is needed for neg=1
    always_comb begin
        prod   = {hi, lo};
        p_next = neg ? (~prod + ONE_P) : prod;
    end

`ifdef SEQ_MULT_OVF_EN
    logic [WIDTH:0] top_bits;
    logic           ovf_next;

    // Fits a WIDTH-bit signed result only if the top WIDTH+1 bits are all equal
    always_comb begin
        top_bits = p_next[2*WIDTH-1:WIDTH-1];
        ovf_next = !((&top_bits) || !(|top_bits));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
`ifdef SEQ_MULT_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ABS;
                    end
                end
                ABS: begin
                    // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1)
                    if (mcand[WIDTH-1]) mcand <= ~mcand + ONE_W;
                    if (lo[WIDTH-1])    lo    <= ~lo + ONE_W;
                    state <= MUL;
                end
                MUL: begin
                    hi  <= hi_step;
                    lo  <= lo_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    p     <= p_next;
`ifdef SEQ_MULT_OVF_EN
                    ovf   <= ovf_next;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_mult.sv
// Directed testbench for seq_signed_mult (WIDTH=8); ovf checks are compiled in
// when SEQ_MULT_OVF_EN is defined.
module tb_seq_signed_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;
`ifdef SEQ_MULT_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int fails  = 0;

    seq_signed_mult #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
`ifdef SEQ_MULT_OVF_EN
        .ovf   (ovf),
`endif
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; returns number of negedges waited
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Issues one start pulse and checks latency, product and the done pulse width
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [15:0] exp_p);
        int cnt;
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        wait_done(cnt);
        check({tag, " latency"}, 32'(cnt), 32'd10);
        check({tag, " p"}, 32'(p), 32'(exp_p));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cnt;
        int n_done;
        logic [15:0] p_seen;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset p", 32'(p), 32'd0);
        rst = 1'b0;

        // Signed basics and corners
        run_op("7x-3", 8'd7, 8'hFD, 16'hFFEB);
        run_op("-5x0", 8'hFB, 8'h00, 16'h0000);
        run_op("-128x-128", 8'h80, 8'h80, 16'h4000);
        run_op("-128x127", 8'h80, 8'h7F, 16'hC080);
        run_op("127x127", 8'h7F, 8'h7F, 16'h3F01);
        run_op("-1x-1", 8'hFF, 8'hFF, 16'h0001);

        // Start held high: second operation accepted in the done cycle
        @(negedge clk);
        a = 8'd7;
        b = 8'hFD;
        start = 1'b1;
        @(negedge clk);
        wait_done(cnt);
        check("held first latency", 32'(cnt), 32'd10);
        check("held first p", 32'(p), 32'h0000FFEB);
        a = 8'hF7;
        b = 8'd11;
        @(negedge clk);
        start = 1'b0;
        check("held second busy", 32'(busy), 32'd1);
        check("held second done low", 32'(done), 32'd0);
        check("held p kept", 32'(p), 32'h0000FFEB);
        wait_done(cnt);
        check("held second latency", 32'(cnt), 32'd10);
        check("held second p", 32'(p), 32'h0000FF9D);

        // Start pulse while busy is ignored; exactly one done
        @(negedge clk);
        a = 8'd12;
        b = 8'hF6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'd99;
        b = 8'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        p_seen = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                p_seen = p;
            end
        end
        check("ignore done count", 32'(n_done), 32'd1);
        check("ignore p", 32'(p_seen), 32'h0000FF88);
        check("ignore busy idle", 32'(busy), 32'd0);

        // Operand changes without start leave p alone
        a = 8'd55;
        b = 8'hFE;
        repeat (5) @(negedge clk);
        check("hold p", 32'(p), 32'h0000FF88);
        check("hold busy", 32'(busy), 32'd0);
        check("hold done", 32'(done), 32'd0);

        // Asynchronous reset during MUL
        @(negedge clk);
        a = 8'd100;
        b = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst p", 32'(p), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midrst no done", 32'(n_done), 32'd0);
        run_op("after rst -6x-7", 8'hFA, 8'hF9, 16'h002A);

`ifdef SEQ_MULT_OVF_EN
        run_op("ovf 16x8", 8'd16, 8'd8, 16'h0080);
        check("ovf 16x8 flag", 32'(ovf), 32'd1);
        run_op("ovf -16x8", 8'hF0, 8'd8, 16'hFF80);
        check("ovf -16x8 flag", 32'(ovf), 32'd0);
        run_op("ovf 3x4", 8'd3, 8'd4, 16'h000C);
        check("ovf 3x4 flag", 32'(ovf), 32'd0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
